// File: rtl/wdt_pkg.sv
// Shared constants for the watchdog bus front end: register offsets,
// CTRL/STAT bit positions, key words and the key sequencer state type.
package wdt_pkg;

    localparam logic [1:0] OFS_KEY        = 2'd0;
    localparam logic [1:0] OFS_PERIOD     = 2'd1;
    localparam logic [1:0] OFS_RST_PERIOD = 2'd2;
    localparam logic [1:0] OFS_CTRL       = 2'd3;

    localparam int CTRL_LOCK_BIT = 0;
    localparam int CTRL_FS_BIT   = 1;
    localparam int CTRL_HR_BIT   = 2;
    localparam int CTRL_CNT_LSB  = 16;

    localparam logic [31:0] WDT_KEY1 = 32'h5555_AAAA;
    localparam logic [31:0] WDT_KEY2 = 32'hAAAA_5555;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_ARMED = 2'd2
    } key_state_t;

endpackage

// File: rtl/wdt_key_fsm.sv
// Two-word key sequencer. Emits a one-cycle init kick after reset release,
// a kick on a correct KEY1/KEY2 pair and key_err on any wrong key word.
// Outputs are combinational decodes; the top registers them.
module wdt_key_fsm
    import wdt_pkg::*;
#(
    parameter logic [31:0] KEY1 = WDT_KEY1,
    parameter logic [31:0] KEY2 = WDT_KEY2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_we,
    input  logic        other_we,
    input  logic [31:0] wdata,
    output logic        init_kick,
    output logic        kick,
    output logic        key_err
);

    key_state_t state_reg;
    key_state_t state_next;

    // State register; reset always restarts at the init kick and drops any armed key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and event decode; writes to other registers abort an armed sequence silently.
    always_comb begin
        state_next = state_reg;
        init_kick  = 1'b0;
        kick       = 1'b0;
        key_err    = 1'b0;
        case (state_reg)
            S_INIT: begin
                init_kick  = 1'b1;
                state_next = S_IDLE;
            end
            S_IDLE: begin
                if (key_we) begin
                    if (wdata == KEY1) begin
                        state_next = S_ARMED;
                    end else begin
                        key_err = 1'b1;
                    end
                end
            end
            S_ARMED: begin
                if (key_we) begin
                    state_next = S_IDLE;
                    if (wdata == KEY2) begin
                        kick = 1'b1;
                    end else begin
                        key_err = 1'b1;
                    end
                end else if (other_we) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_INIT;
            end
        endcase
    end

endmodule

// File: rtl/wdt_bus_ctrl.sv
// CPU-side front end for the watchdog: decodes bus writes into clear pulses,
// wait/reset periods and a guarded kick, and latches watchdog status events.
module wdt_bus_ctrl
    import wdt_pkg::*;
#(
    parameter logic [31:0] DEFAULT_WAIT = 32'd1000,
    parameter logic [31:0] DEFAULT_RST  = 32'd16,
    parameter logic [31:0] KEY1         = WDT_KEY1,
    parameter logic [31:0] KEY2         = WDT_KEY2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_addr,
    input  logic        i_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    input  logic        i_fail_safe,
    input  logic        i_hardware_rst,
    output logic        o_clrwdt,
    output logic [31:0] o_wait_period,
    output logic        o_wait_period_w_en,
    output logic [31:0] o_rst_period,
    output logic        o_key_err
);

    logic [1:0]  offset;
    logic        key_we;
    logic        period_we;
    logic        rst_period_we;
    logic        ctrl_we;
    logic        other_we;

    logic [31:0] period_reg;
    logic [31:0] rst_period_reg;
    logic        dirty_reg;
    logic        lock_reg;
    logic        fs_seen_reg;
    logic        hr_seen_reg;
    logic [15:0] kick_cnt_reg;
    logic        clrwdt_reg;
    logic        w_en_reg;
    logic        key_err_reg;

    logic        init_kick;
    logic        kick;
    logic        key_err;

    // Only word offset is decoded; the byte lanes are deliberately ignored.
    logic        unused_addr_bits;
    assign unused_addr_bits = &{1'b0, i_addr[1:0]};

    assign offset        = i_addr[3:2];
    assign key_we        = i_we && (offset == OFS_KEY);
    assign period_we     = i_we && (offset == OFS_PERIOD);
    assign rst_period_we = i_we && (offset == OFS_RST_PERIOD);
    assign ctrl_we       = i_we && (offset == OFS_CTRL);
    assign other_we      = i_we && (offset != OFS_KEY);

    wdt_key_fsm #(
        .KEY1 (KEY1),
        .KEY2 (KEY2)
    ) u_key_fsm (
        .clk       (i_clk),
        .rst       (i_rst),
        .key_we    (key_we),
        .other_we  (other_we),
        .wdata     (i_wdata),
        .init_kick (init_kick),
        .kick      (kick),
        .key_err   (key_err)
    );

    // Registered service pulses; the init kick always reloads the wait period.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            clrwdt_reg  <= 1'b0;
            w_en_reg    <= 1'b0;
            key_err_reg <= 1'b0;
        end else begin
            clrwdt_reg  <= init_kick | kick;
            w_en_reg    <= init_kick | (kick & dirty_reg);
            key_err_reg <= key_err;
        end
    end

    // Staged wait period; dirty marks a value the watchdog has not loaded yet.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            period_reg <= DEFAULT_WAIT;
            dirty_reg  <= 1'b0;
        end else begin
            if (kick) begin
                dirty_reg <= 1'b0;
            end else if (period_we && !lock_reg) begin
                period_reg <= i_wdata;
                dirty_reg  <= 1'b1;
            end
        end
    end

    // Reset period register, frozen once LOCK is set.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rst_period_reg <= DEFAULT_RST;
        end else if (rst_period_we && !lock_reg) begin
            rst_period_reg <= i_wdata;
        end
    end

    // LOCK is set-only; status bits are sticky W1C where a new event beats the clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lock_reg    <= 1'b0;
            fs_seen_reg <= 1'b0;
            hr_seen_reg <= 1'b0;
        end else begin
            if (ctrl_we && i_wdata[CTRL_LOCK_BIT]) begin
                lock_reg <= 1'b1;
            end
            if (i_fail_safe) begin
                fs_seen_reg <= 1'b1;
            end else if (ctrl_we && i_wdata[CTRL_FS_BIT]) begin
                fs_seen_reg <= 1'b0;
            end
            if (i_hardware_rst) begin
                hr_seen_reg <= 1'b1;
            end else if (ctrl_we && i_wdata[CTRL_HR_BIT]) begin
                hr_seen_reg <= 1'b0;
            end
        end
    end

    // Counts software kicks only, saturating instead of wrapping.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            kick_cnt_reg <= 16'd0;
        end else if (kick && (kick_cnt_reg != 16'hFFFF)) begin
            kick_cnt_reg <= kick_cnt_reg + 16'd1;
        end
    end

    // Combinational readback; KEY is write-only and reads as zero.
    always_comb begin
        o_rdata = 32'd0;
        case (offset)
            OFS_PERIOD:     o_rdata = period_reg;
            OFS_RST_PERIOD: o_rdata = rst_period_reg;
            OFS_CTRL: begin
                o_rdata[CTRL_LOCK_BIT]                 = lock_reg;
                o_rdata[CTRL_FS_BIT]                   = fs_seen_reg;
                o_rdata[CTRL_HR_BIT]                   = hr_seen_reg;
                o_rdata[CTRL_CNT_LSB +: 16]            = kick_cnt_reg;
            end
            default:        o_rdata = 32'd0;
        endcase
    end

    assign o_clrwdt           = clrwdt_reg;
    assign o_wait_period_w_en = w_en_reg;
    assign o_key_err          = key_err_reg;
    assign o_wait_period      = period_reg;
    assign o_rst_period       = rst_period_reg;

endmodule

// File: tb/tb_wdt_bus_ctrl.sv
// Self-checking bench for wdt_bus_ctrl: directed scenarios from the register
// rules plus a randomized run against a transaction-level reference model.
module tb_wdt_bus_ctrl;

    localparam logic [31:0] K1 = 32'h5555_AAAA;
    localparam logic [31:0] K2 = 32'hAAAA_5555;
    localparam logic [3:0] A_KEY = 4'h0;
    localparam logic [3:0] A_PER = 4'h4;
    localparam logic [3:0] A_RST = 4'h8;
    localparam logic [3:0] A_CTL = 4'hC;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [3:0]  i_addr = 4'h0;
    logic        i_we = 1'b0;
    logic [31:0] i_wdata = 32'd0;
    logic [31:0] o_rdata;
    logic        i_fail_safe = 1'b0;
    logic        i_hardware_rst = 1'b0;
    logic        o_clrwdt;
    logic [31:0] o_wait_period;
    logic        o_wait_period_w_en;
    logic [31:0] o_rst_period;
    logic        o_key_err;

    int errors = 0;
    int checks = 0;

    wdt_bus_ctrl dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_addr             (i_addr),
        .i_we               (i_we),
        .i_wdata            (i_wdata),
        .o_rdata            (o_rdata),
        .i_fail_safe        (i_fail_safe),
        .i_hardware_rst     (i_hardware_rst),
        .o_clrwdt           (o_clrwdt),
        .o_wait_period      (o_wait_period),
        .o_wait_period_w_en (o_wait_period_w_en),
        .o_rst_period       (o_rst_period),
        .o_key_err          (o_key_err)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: what software sees, tracked per bus transaction.
    bit          m_init, m_armed, m_lock, m_fs, m_hr, m_dirty;
    logic [31:0] m_period, m_rst_period;
    int          m_kicks;
    logic        exp_clr, exp_wen, exp_err;

    function automatic void model_reset();
        m_init = 1; m_armed = 0; m_lock = 0; m_fs = 0; m_hr = 0; m_dirty = 0;
        m_period = 32'd1000; m_rst_period = 32'd16; m_kicks = 0;
        exp_clr = 0; exp_wen = 0; exp_err = 0;
    endfunction

    function automatic void model_step(input logic we, input logic [3:0] addr,
                                       input logic [31:0] data, input logic fs, input logic hr);
        int word;
        word = int'(addr) / 4;
        exp_clr = 0; exp_wen = 0; exp_err = 0;
        if (m_init) begin
            exp_clr = 1; exp_wen = 1; m_init = 0;
        end else if (we && word == 0) begin
            if (!m_armed) begin
                if (data == K1) m_armed = 1; else exp_err = 1;
            end else begin
                m_armed = 0;
                if (data == K2) begin
                    exp_clr = 1; exp_wen = m_dirty; m_dirty = 0;
                    if (m_kicks < 65535) m_kicks++;
                end else begin
                    exp_err = 1;
                end
            end
        end else if (we) begin
            m_armed = 0;
        end
        if (we && word == 1 && !m_lock) begin m_period = data; m_dirty = 1; end
        if (we && word == 2 && !m_lock) m_rst_period = data;
        if (we && word == 3) begin
            if (data[0]) m_lock = 1;
            if (data[1]) m_fs = 0;
            if (data[2]) m_hr = 0;
        end
        if (fs) m_fs = 1;
        if (hr) m_hr = 1;
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] addr);
        logic [15:0] k;
        k = m_kicks[15:0];
        case (int'(addr) / 4)
            1:       return m_period;
            2:       return m_rst_period;
            3:       return {k, 13'd0, m_hr, m_fs, m_lock};
            default: return 32'd0;
        endcase
    endfunction

    // One bus clock: drive inputs, advance the model, sample 1ns after the edge.
    task automatic bus_cycle(input logic we, input logic [3:0] addr, input logic [31:0] data,
                             input logic fs, input logic hr);
        i_we = we; i_addr = addr; i_wdata = data; i_fail_safe = fs; i_hardware_rst = hr;
        model_step(we, addr, data, fs, hr);
        @(posedge i_clk);
        #1;
        $display("txn we=%0b addr=%h data=%h fs=%0b hr=%0b -> clr=%0b wen=%0b err=%0b wait=%0d rstp=%0d",
                 we, addr, data, fs, hr, o_clrwdt, o_wait_period_w_en, o_key_err, o_wait_period, o_rst_period);
        i_we = 0; i_fail_safe = 0; i_hardware_rst = 0;
    endtask

    task automatic apply_reset();
        i_rst = 1; i_we = 0; i_fail_safe = 0; i_hardware_rst = 0;
        #7;
        @(negedge i_clk);
        i_rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (o_clrwdt !== 1'b0 || o_wait_period_w_en !== 1'b0 || o_key_err !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: got clr=%b wen=%b err=%b required 0 0 0", o_clrwdt, o_wait_period_w_en, o_key_err); end
        checks++; if (o_wait_period !== 32'd1000 || o_rst_period !== 32'd16) begin
            errors++; $display("FAIL reset_periods: got %0d/%0d required 1000/16", o_wait_period, o_rst_period); end
        i_addr = A_CTL; #1;
        checks++; if (o_rdata !== 32'd0) begin
            errors++; $display("FAIL reset_ctrl: got %h required 0", o_rdata); end
        bus_cycle(0, A_KEY, 0, 0, 0);
        checks++; if (o_clrwdt !== 1'b1 || o_wait_period_w_en !== 1'b1 || o_wait_period !== 32'd1000) begin
            errors++; $display("FAIL init_kick: got clr=%b wen=%b wait=%0d required 1 1 1000", o_clrwdt, o_wait_period_w_en, o_wait_period); end
        bus_cycle(0, A_KEY, 0, 0, 0);
        checks++; if (o_clrwdt !== 1'b0 || o_wait_period_w_en !== 1'b0) begin
            errors++; $display("FAIL init_once: got clr=%b wen=%b required 0 0", o_clrwdt, o_wait_period_w_en); end
        i_addr = A_CTL; #1;
        checks++; if (o_rdata[31:16] !== 16'd0) begin
            errors++; $display("FAIL init_kickcnt: got %0d required 0", o_rdata[31:16]); end
    endtask

    task automatic test_kick();
        apply_reset();
        bus_cycle(0, A_KEY, 0, 0, 0);
        bus_cycle(1, A_PER, 32'd500, 0, 0);
        checks++; if (o_wait_period !== 32'd500) begin
            errors++; $display("FAIL period_write: got %0d required 500", o_wait_period); end
        bus_cycle(1, A_KEY, K1, 0, 0);
        checks++; if (o_clrwdt !== 1'b0) begin
            errors++; $display("FAIL key1_no_clr: got %b required 0", o_clrwdt); end
        bus_cycle(1, A_KEY, K2, 0, 0);
        checks++; if (o_clrwdt !== 1'b1 || o_wait_period_w_en !== 1'b1 || o_wait_period !== 32'd500) begin
            errors++; $display("FAIL kick_dirty: got clr=%b wen=%b wait=%0d required 1 1 500", o_clrwdt, o_wait_period_w_en, o_wait_period); end
        bus_cycle(0, A_KEY, 0, 0, 0);
        checks++; if (o_clrwdt !== 1'b0) begin
            errors++; $display("FAIL kick_one_cycle: got %b required 0", o_clrwdt); end
        bus_cycle(1, A_KEY, K1, 0, 0);
        bus_cycle(1, A_KEY, K2, 0, 0);
        checks++; if (o_clrwdt !== 1'b1 || o_wait_period_w_en !== 1'b0) begin
            errors++; $display("FAIL kick_clean: got clr=%b wen=%b required 1 0", o_clrwdt, o_wait_period_w_en); end
        i_addr = A_CTL; #1;
        checks++; if (o_rdata[31:16] !== 16'd2) begin
            errors++; $display("FAIL kick_count: got %0d required 2", o_rdata[31:16]); end
    endtask

    task automatic test_bad_key();
        apply_reset();
        bus_cycle(0, A_KEY, 0, 0, 0);
        bus_cycle(1, A_KEY, K1, 0, 0);
        bus_cycle(1, A_KEY, 32'h1234_5678, 0, 0);
        checks++; if (o_key_err !== 1'b1 || o_clrwdt !== 1'b0) begin
            errors++; $display("FAIL bad_key2: got err=%b clr=%b required 1 0", o_key_err, o_clrwdt); end
        bus_cycle(0, A_KEY, 0, 0, 0);
        checks++; if (o_key_err !== 1'b0) begin
            errors++; $display("FAIL key_err_pulse: got %b required 0", o_key_err); end
        bus_cycle(1, A_KEY, K2, 0, 0);
        checks++; if (o_key_err !== 1'b1 || o_clrwdt !== 1'b0) begin
            errors++; $display("FAIL key2_alone: got err=%b clr=%b required 1 0", o_key_err, o_clrwdt); end
        i_addr = A_KEY; #1;
        checks++; if (o_rdata !== 32'd0) begin
            errors++; $display("FAIL key_read: got %h required 0", o_rdata); end
    endtask

    task automatic test_abort();
        apply_reset();
        bus_cycle(0, A_KEY, 0, 0, 0);
        bus_cycle(1, A_KEY, K1, 0, 0);
        bus_cycle(1, A_RST, 32'd8, 0, 0);
        checks++; if (o_rst_period !== 32'd8 || o_key_err !== 1'b0) begin
            errors++; $display("FAIL abort_write: got rstp=%0d err=%b required 8 0", o_rst_period, o_key_err); end
        bus_cycle(1, A_KEY, K2, 0, 0);
        checks++; if (o_clrwdt !== 1'b0 || o_key_err !== 1'b1) begin
            errors++; $display("FAIL abort_key2: got clr=%b err=%b required 0 1", o_clrwdt, o_key_err); end
        // Reads and idle cycles keep the sequence armed.
        bus_cycle(1, A_KEY, K1, 0, 0);
        bus_cycle(0, A_PER, 32'hDEAD_BEEF, 0, 0);
        bus_cycle(0, A_CTL, 0, 0, 0);
        bus_cycle(1, A_KEY, K2, 0, 0);
        checks++; if (o_clrwdt !== 1'b1) begin
            errors++; $display("FAIL armed_hold: got clr=%b required 1", o_clrwdt); end
    endtask

    task automatic test_lock();
        apply_reset();
        bus_cycle(0, A_KEY, 0, 0, 0);
        bus_cycle(1, A_PER, 32'd0, 0, 0);
        checks++; if (o_wait_period !== 32'd0) begin
            errors++; $display("FAIL period_zero: got %0d required 0", o_wait_period); end
        bus_cycle(1, A_PER, 32'd300, 0, 0);
        bus_cycle(1, A_KEY, K1, 0, 0);
        bus_cycle(1, A_KEY, K2, 0, 0);
        bus_cycle(1, A_CTL, 32'h1, 0, 0);
        bus_cycle(1, A_PER, 32'd7, 0, 0);
        bus_cycle(1, A_RST, 32'd3, 0, 0);
        bus_cycle(1, A_CTL, 32'h0, 0, 0);
        i_addr = A_PER; #1;
        checks++; if (o_rdata !== 32'd300 || o_wait_period !== 32'd300) begin
            errors++; $display("FAIL lock_period: got rd=%0d wait=%0d required 300 300", o_rdata, o_wait_period); end
        checks++; if (o_rst_period !== 32'd16) begin
            errors++; $display("FAIL lock_rst: got %0d required 16", o_rst_period); end
        i_addr = A_CTL; #1;
        checks++; if (o_rdata[0] !== 1'b1) begin
            errors++; $display("FAIL lock_sticky: got %b required 1", o_rdata[0]); end
        bus_cycle(1, A_KEY, K1, 0, 0);
        bus_cycle(1, A_KEY, K2, 0, 0);
        checks++; if (o_clrwdt !== 1'b1 || o_wait_period_w_en !== 1'b0) begin
            errors++; $display("FAIL lock_kick: got clr=%b wen=%b required 1 0", o_clrwdt, o_wait_period_w_en); end
    endtask

    task automatic test_status();
        apply_reset();
        bus_cycle(0, A_KEY, 0, 0, 0);
        bus_cycle(0, A_KEY, 0, 0, 1);
        i_addr = A_CTL; #1;
        checks++; if (o_rdata[2:1] !== 2'b10) begin
            errors++; $display("FAIL hr_capture: got %b required 10", o_rdata[2:1]); end
        bus_cycle(1, A_CTL, 32'h2, 1, 0);
        i_addr = A_CTL; #1;
        checks++; if (o_rdata[2:1] !== 2'b11) begin
            errors++; $display("FAIL set_wins: got %b required 11", o_rdata[2:1]); end
        bus_cycle(1, A_CTL, 32'h2, 0, 0);
        i_addr = A_CTL; #1;
        checks++; if (o_rdata[2:1] !== 2'b10) begin
            errors++; $display("FAIL fs_w1c: got %b required 10", o_rdata[2:1]); end
        bus_cycle(1, A_CTL, 32'h4, 0, 0);
        i_addr = A_CTL; #1;
        checks++; if (o_rdata[2:0] !== 3'b000) begin
            errors++; $display("FAIL hr_w1c: got %b required 000", o_rdata[2:0]); end
    endtask

    task automatic test_midseq_reset();
        apply_reset();
        bus_cycle(0, A_KEY, 0, 0, 0);
        bus_cycle(1, A_RST, 32'd99, 0, 0);
        bus_cycle(1, A_KEY, K1, 0, 0);
        i_rst = 1; #2;
        checks++; if (o_rst_period !== 32'd16 || o_clrwdt !== 1'b0) begin
            errors++; $display("FAIL async_reset: got rstp=%0d clr=%b required 16 0", o_rst_period, o_clrwdt); end
        @(negedge i_clk);
        i_rst = 0;
        model_reset();
        bus_cycle(0, A_KEY, 0, 0, 0);
        checks++; if (o_clrwdt !== 1'b1 || o_wait_period_w_en !== 1'b1) begin
            errors++; $display("FAIL reinit_kick: got clr=%b wen=%b required 1 1", o_clrwdt, o_wait_period_w_en); end
        bus_cycle(1, A_KEY, K2, 0, 0);
        checks++; if (o_clrwdt !== 1'b0 || o_key_err !== 1'b1) begin
            errors++; $display("FAIL armed_cancel: got clr=%b err=%b required 0 1", o_clrwdt, o_key_err); end
    endtask

    task automatic test_random();
        logic        we, fs, hr;
        logic [3:0]  addr, raddr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            we   = ($urandom_range(0, 9) < 6);
            addr = 4'($urandom_range(0, 15));
            case (addr[3:2])
                2'd0: begin
                    case ($urandom_range(0, 2))
                        0:       data = K1;
                        1:       data = K2;
                        default: data = $urandom;
                    endcase
                end
                2'd3:    data = ($urandom & 32'hFFFF_FFFE) | 32'(($urandom_range(0, 59) == 0) ? 1 : 0);
                default: data = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
            endcase
            fs = ($urandom_range(0, 19) == 0);
            hr = ($urandom_range(0, 19) == 0);
            bus_cycle(we, addr, data, fs, hr);
            checks++; if (o_clrwdt !== exp_clr) begin
                errors++; $display("FAIL rnd_clr[%0d]: got %b required %b", n, o_clrwdt, exp_clr); end
            checks++; if (o_wait_period_w_en !== exp_wen) begin
                errors++; $display("FAIL rnd_wen[%0d]: got %b required %b", n, o_wait_period_w_en, exp_wen); end
            checks++; if (o_key_err !== exp_err) begin
                errors++; $display("FAIL rnd_err[%0d]: got %b required %b", n, o_key_err, exp_err); end
            checks++; if (o_wait_period !== m_period || o_rst_period !== m_rst_period) begin
                errors++; $display("FAIL rnd_periods[%0d]: got %h/%h required %h/%h", n, o_wait_period, o_rst_period, m_period, m_rst_period); end
            raddr = 4'($urandom_range(0, 15));
            i_addr = raddr; #1;
            exp_rd = model_read(raddr);
            checks++; if (o_rdata !== exp_rd) begin
                errors++; $display("FAIL rnd_read[%0d] addr=%h: got %h required %h", n, raddr, o_rdata, exp_rd); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_kick();
        test_bad_key();
        test_abort();
        test_lock();
        test_status();
        test_midseq_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wdt_bus_ctrl.md
Name: wdt_bus_ctrl

Overview:
Memory-mapped CPU-side front end for watchdog_timer. It decodes MIPS data-bus writes into the watchdog service signals: the clear pulse, the wait-period value, its write enable and the reset-period value. A two-word key sequence guards every kick, so a runaway program cannot service the watchdog by accident. It also latches watchdog status (fail-safe, hardware-reset events) for software readback.

Parameters:
DEFAULT_WAIT, 32'd1000, wait period loaded by the post-reset init kick
DEFAULT_RST, 32'd16, reset period driven on o_rst_period after reset
KEY1, 32'h5555_AAAA, first key word
KEY2, 32'hAAAA_5555, second key word

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous active-high reset
i_addr  in  4  byte address within block; only [3:2] is decoded
i_we  in  1  bus write strobe, one cycle per write
i_wdata  in  32  bus write data
o_rdata  out  32  combinational read data for i_addr
i_fail_safe  in  1  from watchdog o_fail_safe
i_hardware_rst  in  1  from watchdog o_hardware_rst
o_clrwdt  out  1  one-cycle clear pulse to watchdog
o_wait_period  out  32  to watchdog i_wait_period
o_wait_period_w_en  out  1  high only together with o_clrwdt
o_rst_period  out  32  to watchdog i_rst_period
o_key_err  out  1  one-cycle pulse on a bad key write

Behaviour:
- Register map (word offset = i_addr[3:2]):
  - 0 KEY: write-only; reads 0.
  - 1 PERIOD: R/W, value staged for the next kick.
  - 2 RST_PERIOD: R/W.
  - 3 CTRL/STAT:
    - bit0 LOCK: write-1-sets; cleared only by i_rst.
    - bit1 FS_SEEN and bit2 HR_SEEN: sticky; cleared by writing 1 to the same bit (W1C).
    - bits[31:16] KICK_CNT: read-only.
- Reset values:
  - o_clrwdt=0, o_wait_period_w_en=0, o_key_err=0.
  - o_wait_period=DEFAULT_WAIT, o_rst_period=DEFAULT_RST, PERIOD=DEFAULT_WAIT.
  - LOCK=0, FS_SEEN=0, HR_SEEN=0, KICK_CNT=0, dirty=0.
  - FSM state = S_INIT.
- FSM states: S_INIT, S_IDLE, S_ARMED.
  - S_INIT: first clock after reset release drives o_clrwdt=1 and o_wait_period_w_en=1, so the watchdog loads DEFAULT_WAIT. Next state S_IDLE. KICK_CNT is not incremented.
  - S_IDLE:
    - KEY write == KEY1 -> S_ARMED.
    - KEY write of any other value -> o_key_err pulse, stay S_IDLE.
  - S_ARMED:
    - KEY write == KEY2 -> kick, then S_IDLE.
    - KEY write of any other value -> o_key_err pulse, then S_IDLE.
    - Write to any other register -> abort to S_IDLE, no error pulse; that register write still takes effect.
    - Reads and idle cycles do not disturb S_ARMED.
- Kick: registered outputs, so o_clrwdt is high exactly one cycle, the cycle after the KEY2 write.
  - If dirty=1: o_wait_period_w_en=1 in the same cycle, and dirty clears.
  - KICK_CNT increments, saturating at 16'hFFFF.
- PERIOD write: updates PERIOD and o_wait_period immediately, sets dirty.
  - Ignored when LOCK=1. Writes to RST_PERIOD are likewise ignored when LOCK=1.
  - A write of 0 is accepted.
- o_rst_period = RST_PERIOD register value at all times.
- Status capture, sampled every clock:
  - i_fail_safe=1 sets FS_SEEN; i_hardware_rst=1 sets HR_SEEN.
  - If capture and a W1C land in the same cycle, set wins.
- Simultaneous PERIOD write and kick cannot occur: one write per cycle.
- Asserting i_rst mid-sequence returns the FSM to S_INIT and cancels any armed key. The init kick repeats after release.

Decomposition:
- Package wdt_pkg:
  - register offsets (KEY/PERIOD/RST_PERIOD/CTRL)
  - CTRL bit positions
  - KEY1/KEY2 constants
  - FSM state enum
- Optional sub-module: wdt_key_fsm, holding the 3-state key sequencer and emitting kick/key_err.
- Register file and status capture stay in the top.

Test Plan:
- Reset release -> o_clrwdt and o_wait_period_w_en high for exactly 1 cycle with o_wait_period=1000. Then idle, with KICK_CNT=0.
- Write PERIOD=500, then KEY 5555AAAA, then KEY AAAA5555 -> next cycle o_clrwdt=1, w_en=1, o_wait_period=500. A second identical key pair -> o_clrwdt=1, w_en=0, KICK_CNT=2.
- KEY 5555AAAA, then KEY 12345678 -> o_key_err 1-cycle pulse, no clrwdt. KEY AAAA5555 alone -> o_key_err, no clrwdt.
- KEY1, then write RST_PERIOD=8, then KEY2 -> no kick, o_key_err pulse, o_rst_period=8.
- Set LOCK, write PERIOD=7 -> readback stays at the prior value, o_wait_period unchanged. A key pair still kicks with w_en=0.
- Pulse i_hardware_rst for 1 cycle -> CTRL bit2=1. A W1C in the same cycle as i_fail_safe=1 -> bit1 remains 1. A later W1C clears it.
